// File: rtl/rs232out_arbiter_pkg.sv
// Shared types for the rs232out arbiter: FSM state encoding and requester bound.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rs232out_arbiter_pkg;

  // Maximum number of requesters the arbiter is built for.
  localparam int NREQ_MAX = 8;

  // IDLE: no owner. OWN: owner may hand over a byte.
  // LOAD: tx_we pulse cycle. GAP: lets rs232out raise busy before OWN gates on it.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_LOAD = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

endpackage

// File: rtl/rs232out_arbiter_rr_pick.sv
// Round-robin picker: first asserted request strictly after 'last', wrapping modulo NREQ.
// Latency: combinational.
// Backpressure: none; found=0 when no request is asserted.
module rs232out_arbiter_rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scan from farthest to nearest so the nearest candidate after 'last' is written last and wins.
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand  = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IDX_W'((int'(last) + k) % NREQ);
      if (req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs232out_arbiter.sv
// Shares one rs232out transmitter among NREQ byte producers, round-robin with optional message lock.
// Latency: valid to tx_we in 2 cycles when idle; tx_we is a registered single-cycle pulse.
// Backpressure: req_ready only for the owner, only in OWN, only while tx_busy is low.
module rs232out_arbiter
  import rs232out_arbiter_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int LOCK      = 1,
  parameter int TIMEOUT   = 1024,
  parameter int TIMEOUT_W = 11
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        tx_data,
  output logic              tx_we,
  input  logic              tx_busy,
  output logic [NREQ-1:0]   grant,
  output logic              locked
);

  localparam int IDX_W = $clog2(NREQ);

  state_t               state, state_n;
  logic [IDX_W-1:0]     owner, owner_n;
  logic [IDX_W-1:0]     rr, rr_n;
  logic [TIMEOUT_W-1:0] timer, timer_n;
  logic [7:0]           tx_data_n;
  logic                 tx_we_n;
  logic [NREQ-1:0]      grant_n;
  logic                 locked_n;

  logic [IDX_W-1:0]     pick;
  logic                 found;
  logic                 owner_valid;
  logic                 owner_last;
  logic [7:0]           owner_byte;
  logic                 accept;

  rs232out_arbiter_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req_valid),
    .last  (rr),
    .idx   (pick),
    .found (found)
  );

  // Select the current owner's valid, last flag and byte.
  always_comb begin
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_byte  = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      if (owner == IDX_W'(i)) begin
        owner_valid = req_valid[i];
        owner_last  = req_last[i];
        owner_byte  = req_data[8*i +: 8];
      end
    end
  end

  // Only the owner sees ready, and only when the transmitter is free; this also covers
  // a frame still in flight from before a reset, since rs232out itself is never reset.
  always_comb begin
    req_ready = '0;
    if (state == ST_OWN && !tx_busy) begin
      req_ready = grant;
    end
  end

  assign accept = (state == ST_OWN) && owner_valid && !tx_busy;

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    state_n   = state;
    owner_n   = owner;
    rr_n      = rr;
    timer_n   = timer;
    tx_data_n = tx_data;
    tx_we_n   = 1'b0;
    grant_n   = grant;
    locked_n  = locked;
    case (state)
      ST_IDLE: begin
        grant_n  = '0;
        locked_n = 1'b0;
        if (found) begin
          owner_n = pick;
          rr_n    = pick;
          grant_n = NREQ'(1) << pick;
          timer_n = '0;
          state_n = ST_OWN;
        end
      end
      ST_OWN: begin
        if (accept) begin
          tx_data_n = owner_byte;
          tx_we_n   = 1'b1;
          locked_n  = (LOCK != 0) && !owner_last;
          timer_n   = '0;
          state_n   = ST_LOAD;
        end else if (!owner_valid) begin
          if (locked) begin
            // A stalled lock owner must not starve everyone else forever.
            if (timer == TIMEOUT_W'(TIMEOUT - 1)) begin
              locked_n = 1'b0;
              grant_n  = '0;
              timer_n  = '0;
              state_n  = ST_IDLE;
            end else begin
              timer_n = timer + 1'b1;
            end
          end else begin
            grant_n = '0;
            state_n = ST_IDLE;
          end
        end
      end
      ST_LOAD: begin
        state_n = ST_GAP;
      end
      ST_GAP: begin
        if (locked) begin
          timer_n = '0;
          state_n = ST_OWN;
        end else begin
          grant_n = '0;
          state_n = ST_IDLE;
        end
      end
      default: begin
        grant_n  = '0;
        locked_n = 1'b0;
        state_n  = ST_IDLE;
      end
    endcase
  end

  // State and output registers; rr starts at NREQ-1 so requester 0 wins first.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      owner   <= '0;
      rr      <= IDX_W'(NREQ - 1);
      timer   <= '0;
      tx_data <= 8'h00;
      tx_we   <= 1'b0;
      grant   <= '0;
      locked  <= 1'b0;
    end else begin
      state   <= state_n;
      owner   <= owner_n;
      rr      <= rr_n;
      timer   <= timer_n;
      tx_data <= tx_data_n;
      tx_we   <= tx_we_n;
      grant   <= grant_n;
      locked  <= locked_n;
    end
  end

endmodule

// File: tb/tb_rs232out_arbiter.sv
// Directed bench for rs232out_arbiter with a behavioural rs232out (4 cycles per bit) and serial decoder.
// Latency: n/a.
// Backpressure: per-requester byte buffers pop on valid&ready.
module tb_rs232out_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_we;
  logic        tx_busy;
  logic [3:0]  grant;
  logic        locked;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  rs232out_arbiter #(
    .NREQ      (4),
    .LOCK      (1),
    .TIMEOUT   (64),
    .TIMEOUT_W (7)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_we     (tx_we),
    .tx_busy   (tx_busy),
    .grant     (grant),
    .locked    (locked)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural rs232out: no reset, busy rises the cycle after we, 10 bits of 4 cycles.
  logic [9:0] sh = 10'h3FF;
  logic       busy_m = 1'b0;
  int         div_m = 0;
  int         bits_m = 0;
  logic       serial;
  always @(posedge clock) begin
    if (!busy_m) begin
      if (tx_we) begin
        sh     <= {1'b1, tx_data, 1'b0};
        busy_m <= 1'b1;
        div_m  <= 0;
        bits_m <= 0;
      end
    end else if (div_m == 3) begin
      div_m  <= 0;
      sh     <= {1'b1, sh[9:1]};
      bits_m <= bits_m + 1;
      if (bits_m == 9) busy_m <= 1'b0;
    end else begin
      div_m <= div_m + 1;
    end
  end
  assign tx_busy = busy_m;
  assign serial  = busy_m ? sh[0] : 1'b1;

  // Serial decoder: mid-bit sampling, received bytes queued, bad stop bits counted.
  logic [7:0] rx_q[$];
  int         stop_bad = 0;
  initial begin
    logic [7:0] rxb;
    forever begin
      @(negedge clock);
      if (serial === 1'b0) begin
        repeat (2) @(negedge clock);
        for (int b = 0; b < 8; b++) begin
          repeat (4) @(negedge clock);
          rxb[b] = serial;
        end
        repeat (4) @(negedge clock);
        if (serial !== 1'b1) stop_bad = stop_bad + 1;
        rx_q.push_back(rxb);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Protocol monitor: we vs busy, ready vs busy, ready one-hot-or-zero, we spacing.
  initial begin
    int last_we = -100;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (tx_we && tx_busy) chk("we_while_busy", 1, 0);
        if ((req_ready != 0) && tx_busy) chk("ready_while_busy", {28'd0, req_ready}, 0);
        if ((req_ready & (req_ready - 4'd1)) != 0) chk("ready_onehot0", {28'd0, req_ready}, 0);
        if (tx_we) begin
          chk("we_spacing_ge3", (cyc - last_we >= 3) ? 1 : 0, 1);
          last_we = cyc;
        end
      end
    end
  end

  // Producer buffers; acceptance is sampled mid-cycle, popped after the edge.
  logic [8:0] pbuf[4][8];
  int         phead[4] = '{0, 0, 0, 0};
  int         ptail[4] = '{0, 0, 0, 0};
  logic [3:0] acc = '0;
  always @(negedge clock) acc <= req_valid & req_ready;

  task automatic drive();
    logic [8:0] e;
    for (int i = 0; i < 4; i++) begin
      e = pbuf[i][phead[i] % 8];
      req_valid[i]       = (phead[i] != ptail[i]);
      req_last[i]        = e[8];
      req_data[8*i +: 8] = e[7:0];
    end
  endtask

  task automatic push(input int c, input logic l, input logic [7:0] d);
    pbuf[c][ptail[c] % 8] = {l, d};
    ptail[c] = ptail[c] + 1;
    drive();
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    for (int i = 0; i < 4; i++) if (acc[i]) phead[i] = phead[i] + 1;
    drive();
  endtask

  task automatic wait_we(input string tag);
    int n = 0;
    while (tx_we !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    chk(tag, {31'd0, tx_we}, 1);
  endtask

  task automatic wait_rx(input string tag, input int cnt);
    int n = 0;
    while (rx_q.size() < cnt && n < 1500) begin
      step();
      n++;
    end
    chk(tag, rx_q.size(), cnt);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int early;
    drive();
    step();
    step();
    // Reset state.
    chk("rst_tx_we", {31'd0, tx_we}, 0);
    chk("rst_tx_data", {24'd0, tx_data}, 0);
    chk("rst_grant", {28'd0, grant}, 0);
    chk("rst_locked", {31'd0, locked}, 0);
    chk("rst_ready", {28'd0, req_ready}, 0);
    reset = 1'b0;
    step();

    // 1: single byte from client 2.
    push(2, 1'b1, 8'h55);
    step();
    chk("t1_grant_own", {28'd0, grant}, 4);
    chk("t1_ready", {28'd0, req_ready}, 4);
    chk("t1_we_not_yet", {31'd0, tx_we}, 0);
    step();
    chk("t1_we", {31'd0, tx_we}, 1);
    chk("t1_data", {24'd0, tx_data}, 8'h55);
    chk("t1_unlocked", {31'd0, locked}, 0);
    step();
    chk("t1_we_pulse", {31'd0, tx_we}, 0);
    chk("t1_busy", {31'd0, tx_busy}, 1);
    step();
    chk("t1_grant_released", {28'd0, grant}, 0);
    wait_rx("t1_rx_count", 1);
    chk("t1_rx_byte", {24'd0, rx_q[0]}, 8'h55);
    chk("t1_stop", stop_bad, 0);
    rx_q.delete();

    // 2: clients 0,1,3 together, one byte per message; round-robin order.
    do_reset();
    push(0, 1'b1, 8'h10);
    push(0, 1'b1, 8'h20);
    push(1, 1'b1, 8'h11);
    push(3, 1'b1, 8'h13);
    push(3, 1'b1, 8'h33);
    wait_rx("t2_rx_count", 5);
    chk("t2_rx0", {24'd0, rx_q[0]}, 8'h10);
    chk("t2_rx1", {24'd0, rx_q[1]}, 8'h11);
    chk("t2_rx2", {24'd0, rx_q[2]}, 8'h13);
    chk("t2_rx3", {24'd0, rx_q[3]}, 8'h20);
    chk("t2_rx4", {24'd0, rx_q[4]}, 8'h33);
    rx_q.delete();

    // 3: locked two-byte message from client 1 while client 0 waits.
    push(0, 1'b1, 8'h30);
    wait_rx("t3_pre_rx", 1);
    push(1, 1'b0, 8'h41);
    push(1, 1'b1, 8'h42);
    push(0, 1'b1, 8'h31);
    wait_we("t3_we_a");
    chk("t3_data_a", {24'd0, tx_data}, 8'h41);
    chk("t3_locked", {31'd0, locked}, 1);
    chk("t3_grant", {28'd0, grant}, 2);
    wait_rx("t3_rx_count", 4);
    chk("t3_rx1", {24'd0, rx_q[1]}, 8'h41);
    chk("t3_rx2", {24'd0, rx_q[2]}, 8'h42);
    chk("t3_rx3", {24'd0, rx_q[3]}, 8'h31);
    rx_q.delete();

    // 4: lock timeout, with an accept in between restarting the count.
    push(1, 1'b0, 8'h61);
    push(0, 1'b1, 8'h50);
    wait_we("t4_we_a");
    chk("t4_data_a", {24'd0, tx_data}, 8'h61);
    step();
    step();
    chk("t4_own_locked", {31'd0, locked}, 1);
    chk("t4_own_grant", {28'd0, grant}, 2);
    repeat (20) step();
    push(1, 1'b0, 8'h62);
    wait_we("t4_we_b");
    chk("t4_data_b", {24'd0, tx_data}, 8'h62);
    step();
    step();
    early = 0;
    for (int i = 0; i < 63; i++) begin
      step();
      if (locked !== 1'b1) early++;
    end
    chk("t4_lock_held_63", early, 0);
    step();
    chk("t4_timeout_unlock", {31'd0, locked}, 0);
    chk("t4_timeout_grant0", {28'd0, grant}, 0);
    step();
    chk("t4_client0_grant", {28'd0, grant}, 1);
    wait_rx("t4_rx_count", 3);
    chk("t4_rx0", {24'd0, rx_q[0]}, 8'h61);
    chk("t4_rx1", {24'd0, rx_q[1]}, 8'h62);
    chk("t4_rx2", {24'd0, rx_q[2]}, 8'h50);
    rx_q.delete();
    repeat (4) step();

    // 5a: reset during LOAD drops we at once.
    push(2, 1'b1, 8'h77);
    wait_we("t5_we");
    reset = 1'b1;
    #1;
    chk("t5_we_async", {31'd0, tx_we}, 0);
    chk("t5_grant_async", {28'd0, grant}, 0);
    chk("t5_data_async", {24'd0, tx_data}, 0);
    step();
    reset = 1'b0;
    step();
    chk("t5_no_frame", {31'd0, tx_busy}, 0);

    // 5b: reset while a frame is in flight; next byte waits for busy to fall.
    push(2, 1'b1, 8'h78);
    wait_we("t5b_we");
    step();
    chk("t5b_busy", {31'd0, tx_busy}, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    push(3, 1'b1, 8'h79);
    step();
    step();
    chk("t5b_grant", {28'd0, grant}, 8);
    chk("t5b_no_ready", {28'd0, req_ready}, 0);
    wait_we("t5b_we2");
    chk("t5b_data2", {24'd0, tx_data}, 8'h79);
    wait_rx("t5b_rx_count", 2);
    chk("t5b_rx0", {24'd0, rx_q[0]}, 8'h78);
    chk("t5b_rx1", {24'd0, rx_q[1]}, 8'h79);
    chk("stop_bits", stop_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
